// File: rtl/apf_wishbone_mem_slave.sv
// Wishbone classic single-beat slave that forwards accesses inside one address
// window to a ready/valid word-memory port. Out-of-window or stalled accesses
// terminate with wb_err_o; a read abandoned by the master is drained so its late
// return is never attributed to a later transfer.

module apf_wishbone_mem_slave #(
   parameter logic [29:0] ADDR_BASE      = 30'h0,
   parameter logic [29:0] ADDR_WORDS     = 30'h0040_0000,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk_sys_i,
   input  logic        reset_n_i,

   // Wishbone slave
   input  logic [29:0] wb_adr_i,
   input  logic [31:0] wb_dat_w_i,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic [2:0]  wb_cti_i,
   input  logic [1:0]  wb_bte_i,
   output logic [31:0] wb_dat_r_o,
   output logic        wb_ack_o,
   output logic        wb_err_o,

   // Word-memory request/return port
   output logic [23:0] mem_addr_o,
   output logic        mem_wr_o,
   output logic        mem_rd_o,
   output logic [31:0] mem_wdata_o,
   output logic [3:0]  mem_be_o,
   input  logic        mem_ready_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i
);

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StWaitRd,
      StResp,
      StErr,
      StDrain
   } state_e;

   // Window compare is done one bit wider so base + size never wraps at 2^30.
   localparam logic [30:0] BaseExt     = {1'b0, ADDR_BASE};
   localparam logic [30:0] WordsExt    = {1'b0, ADDR_WORDS};
   // Counter starts at 0 in the first ISSUE cycle, so this value marks the
   // TIMEOUT_CYCLES-th busy cycle.
   localparam logic [7:0]  TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

   state_e      state_q, state_d;

   logic        we_q, we_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [23:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [3:0]  mem_be_q, mem_be_d;
   logic        mem_wr_q, mem_wr_d;
   logic        mem_rd_q, mem_rd_d;
   logic        wb_ack_q, wb_ack_d;
   logic        wb_err_q, wb_err_d;
   logic [31:0] wb_dat_r_q, wb_dat_r_d;

   logic [30:0] adr_ext;
   logic [30:0] adr_off;
   logic        win_hit;
   logic        wb_req;
   logic        null_write;
   logic        accept;
   logic        timeout;

   // Cycle-type and burst hints carry no meaning here; every access is one beat.
   logic        unused_ok;
   assign unused_ok = ^{wb_cti_i, wb_bte_i, adr_off[30:24]};

   assign adr_ext    = {1'b0, wb_adr_i};
   assign adr_off    = adr_ext - BaseExt;
   assign win_hit    = (adr_ext >= BaseExt) && (adr_off < WordsExt);
   assign wb_req     = wb_cyc_i & wb_stb_i;
   assign null_write = wb_we_i && (wb_sel_i == 4'h0);
   assign accept     = (state_q == StIdle) && wb_req && win_hit && !null_write;
   assign timeout    = (cnt_q == TimeoutLast);

   // State register.
   always_ff @(posedge clk_sys_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (wb_req) begin
               if (!win_hit) begin
                  state_d = StErr;
               end else if (null_write) begin
                  state_d = StResp;
               end else begin
                  state_d = StIssue;
               end
            end
         end
         StIssue: begin
            // An accepted request has reached memory even if the master has
            // just left; a read in that case still has a return to absorb.
            if (mem_ready_i) begin
               if (we_q) begin
                  state_d = wb_cyc_i ? StResp : StIdle;
               end else begin
                  state_d = wb_cyc_i ? StWaitRd : StDrain;
               end
            end else if (!wb_cyc_i) begin
               state_d = StIdle;
            end else if (timeout) begin
               state_d = StErr;
            end
         end
         StWaitRd: begin
            // Arrived data takes priority over both abort and timeout.
            if (mem_rvalid_i) begin
               state_d = wb_cyc_i ? StResp : StIdle;
            end else if (!wb_cyc_i) begin
               state_d = StDrain;
            end else if (timeout) begin
               state_d = StErr;
            end
         end
         StDrain: begin
            if (mem_rvalid_i || timeout) begin
               state_d = StIdle;
            end
         end
         StResp: state_d = StIdle;
         StErr:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Next values of the registered outputs and request latches.
   always_comb begin
      we_d        = we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_be_d    = mem_be_q;
      wb_dat_r_d  = wb_dat_r_q;

      if (accept) begin
         we_d        = wb_we_i;
         mem_addr_d  = adr_off[23:0];
         mem_wdata_d = wb_dat_w_i;
         mem_be_d    = wb_sel_i;
      end

      // Only a return seen in WAIT_RD is ours; DRAIN discards it.
      if ((state_q == StWaitRd) && mem_rvalid_i) begin
         wb_dat_r_d = mem_rdata_i;
      end

      if (state_q == StIdle) begin
         cnt_d = 8'd0;
      end else if ((state_q == StIssue) || (state_q == StWaitRd) || (state_q == StDrain)) begin
         cnt_d = cnt_q + 8'd1;
      end else begin
         cnt_d = cnt_q;
      end

      // Strobes follow the state being entered so they are registered.
      mem_wr_d = (state_d == StIssue) && we_d;
      mem_rd_d = (state_d == StIssue) && !we_d;
      wb_ack_d = (state_d == StResp);
      wb_err_d = (state_d == StErr);
   end

   // Output and datapath registers.
   always_ff @(posedge clk_sys_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         we_q        <= 1'b0;
         cnt_q       <= 8'd0;
         mem_addr_q  <= 24'd0;
         mem_wdata_q <= 32'd0;
         mem_be_q    <= 4'd0;
         mem_wr_q    <= 1'b0;
         mem_rd_q    <= 1'b0;
         wb_ack_q    <= 1'b0;
         wb_err_q    <= 1'b0;
         wb_dat_r_q  <= 32'd0;
      end else begin
         we_q        <= we_d;
         cnt_q       <= cnt_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_be_q    <= mem_be_d;
         mem_wr_q    <= mem_wr_d;
         mem_rd_q    <= mem_rd_d;
         wb_ack_q    <= wb_ack_d;
         wb_err_q    <= wb_err_d;
         wb_dat_r_q  <= wb_dat_r_d;
      end
   end

   assign wb_dat_r_o  = wb_dat_r_q;
   assign wb_ack_o    = wb_ack_q;
   assign wb_err_o    = wb_err_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wr_o    = mem_wr_q;
   assign mem_rd_o    = mem_rd_q;
   assign mem_wdata_o = mem_wdata_q;
   assign mem_be_o    = mem_be_q;

endmodule

// File: tb/tb_apf_wishbone_mem_slave.sv
// Directed and randomised bench for apf_wishbone_mem_slave with a termination
// scoreboard and a small word-memory responder.

module tb_apf_wishbone_mem_slave;

   logic        clk_sys;
   logic        reset_n;
   logic [29:0] wb_adr;
   logic [31:0] wb_dat_w;
   logic [3:0]  wb_sel;
   logic        wb_cyc, wb_stb, wb_we;
   logic [2:0]  wb_cti;
   logic [1:0]  wb_bte;
   logic [31:0] wb_dat_r;
   logic        wb_ack, wb_err;
   logic [23:0] mem_addr;
   logic        mem_wr, mem_rd;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ready, mem_rvalid;
   logic [31:0] mem_rdata;

   apf_wishbone_mem_slave #(
      .ADDR_BASE      (30'h100),
      .ADDR_WORDS     (30'h40),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk_sys_i    (clk_sys),
      .reset_n_i    (reset_n),
      .wb_adr_i     (wb_adr),
      .wb_dat_w_i   (wb_dat_w),
      .wb_sel_i     (wb_sel),
      .wb_cyc_i     (wb_cyc),
      .wb_stb_i     (wb_stb),
      .wb_we_i      (wb_we),
      .wb_cti_i     (wb_cti),
      .wb_bte_i     (wb_bte),
      .wb_dat_r_o   (wb_dat_r),
      .wb_ack_o     (wb_ack),
      .wb_err_o     (wb_err),
      .mem_addr_o   (mem_addr),
      .mem_wr_o     (mem_wr),
      .mem_rd_o     (mem_rd),
      .mem_wdata_o  (mem_wdata),
      .mem_be_o     (mem_be),
      .mem_ready_i  (mem_ready),
      .mem_rvalid_i (mem_rvalid),
      .mem_rdata_i  (mem_rdata)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   // Memory side: manual drive for directed steps, random-stall model otherwise.
   logic        auto_mode;
   logic        man_ready, man_rvalid;
   logic [31:0] man_rdata;
   logic        rdy_rnd_q, rvalid_q, rd_pend;
   logic [2:0]  stall_q;
   logic [1:0]  rd_dly;
   logic [5:0]  rd_idx;
   logic [31:0] rdata_q;
   logic [31:0] mem_model [64];
   logic [31:0] ref_mem [64];

   assign mem_ready  = auto_mode ? (rdy_rnd_q | (stall_q >= 3'd2)) : man_ready;
   assign mem_rvalid = auto_mode ? rvalid_q : man_rvalid;
   assign mem_rdata  = auto_mode ? rdata_q : man_rdata;

   // Responder: accepts one request, returns reads after 0..2 extra cycles.
   always @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         rdy_rnd_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rd_pend   <= 1'b0;
         stall_q   <= 3'd0;
         rd_dly    <= 2'd0;
         rd_idx    <= 6'd0;
         rdata_q   <= 32'd0;
         for (int i = 0; i < 64; i++) mem_model[i] <= 32'd0;
      end else begin
         rdy_rnd_q <= 1'($urandom_range(0, 1));
         rvalid_q  <= 1'b0;
         if ((mem_wr || mem_rd) && !mem_ready) stall_q <= stall_q + 3'd1;
         else stall_q <= 3'd0;
         if (auto_mode) begin
            if (mem_wr && mem_ready) begin
               for (int b = 0; b < 4; b++)
                  if (mem_be[b]) mem_model[mem_addr[5:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
            if (mem_rd && mem_ready) begin
               rd_pend <= 1'b1;
               rd_dly  <= 2'($urandom_range(0, 2));
               rd_idx  <= mem_addr[5:0];
            end else if (rd_pend) begin
               if (rd_dly == 2'd0) begin
                  rvalid_q <= 1'b1;
                  rdata_q  <= mem_model[rd_idx];
                  rd_pend  <= 1'b0;
               end else begin
                  rd_dly <= rd_dly - 2'd1;
               end
            end
         end
      end
   end

   typedef struct packed {
      logic        is_err;
      logic        chk_data;
      logic [31:0] data;
   } exp_t;

   exp_t sb_q[$];
   int   n_chk;
   int   n_pass;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   task automatic push(input logic is_err, input logic chk_data, input logic [31:0] data);
      exp_t e;
      e.is_err   = is_err;
      e.chk_data = chk_data;
      e.data     = data;
      sb_q.push_back(e);
   endtask

   // Advance one cycle, then score any termination seen in the new cycle.
   task automatic tick();
      exp_t e;
      @(posedge clk_sys);
      #1;
      if (wb_ack || wb_err) begin
         chk("ack_err_excl", 32'(wb_ack & wb_err), 32'd0);
         if (sb_q.size() == 0) begin
            chk("sb_spurious", 32'({wb_ack, wb_err}), 32'd0);
         end else begin
            e = sb_q.pop_front();
            chk("sb_kind", 32'(wb_err), 32'(e.is_err));
            if (e.chk_data && wb_ack) chk("sb_rdata", wb_dat_r, e.data);
         end
      end
      if (auto_mode && (mem_wr || mem_rd))
         chk("no_overlap", 32'({rd_pend, rvalid_q, mem_wr & mem_rd}), 32'd0);
   endtask

   task automatic drive(input logic we, input logic [29:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel);
      wb_we    = we;
      wb_adr   = adr;
      wb_dat_w = dat;
      wb_sel   = sel;
      wb_cyc   = 1'b1;
      wb_stb   = 1'b1;
   endtask

   task automatic idle_bus();
      wb_cyc = 1'b0;
      wb_stb = 1'b0;
      wb_we  = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_strobes"}, 32'({wb_ack, wb_err, mem_wr, mem_rd}), 32'd0);
      chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
      chk({tag, "_dat_r"}, wb_dat_r, 32'd0);
      chk({tag, "_wdata"}, mem_wdata, 32'd0);
      chk({tag, "_be"}, 32'(mem_be), 32'd0);
   endtask

   logic [29:0] r_adr;
   logic [31:0] r_dat;
   logic [3:0]  r_sel;
   logic        r_we;
   int          r_kind;
   int          guard;

   initial begin
      reset_n = 1'b0;
      n_chk = 0;
      n_pass = 0;
      auto_mode = 1'b0;
      man_ready = 1'b0;
      man_rvalid = 1'b0;
      man_rdata = 32'd0;
      wb_adr = 30'd0;
      wb_dat_w = 32'd0;
      wb_sel = 4'd0;
      wb_cti = 3'd0;
      wb_bte = 2'd0;
      idle_bus();
      for (int i = 0; i < 64; i++) ref_mem[i] = 32'd0;
      repeat (3) @(posedge clk_sys);
      #3;
      chk_all_zero("reset");
      reset_n = 1'b1;
      tick();

      // Write at 0x105 with memory always ready.
      man_ready = 1'b1;
      drive(1'b1, 30'h105, 32'hDEADBEEF, 4'hF);
      push(1'b0, 1'b0, 32'd0);
      tick();
      chk("wr_c1_mem_wr", 32'({mem_wr, mem_rd}), 32'b10);
      chk("wr_c1_addr", 32'(mem_addr), 32'd5);
      chk("wr_c1_be", 32'(mem_be), 32'hF);
      chk("wr_c1_wdata", mem_wdata, 32'hDEADBEEF);
      chk("wr_c1_noack", 32'(wb_ack), 32'd0);
      tick();
      chk("wr_c2_ack", 32'({wb_ack, mem_wr}), 32'b10);
      idle_bus();
      tick();
      chk("wr_c3_single_ack", 32'(wb_ack), 32'd0);

      // Read at 0x100: ready after 3 stall cycles, data 4 cycles after that.
      man_ready = 1'b0;
      drive(1'b0, 30'h100, 32'd0, 4'hF);
      push(1'b0, 1'b1, 32'h12345678);
      tick();
      chk("rd_addr", 32'(mem_addr), 32'd0);
      for (int i = 0; i < 3; i++) begin
         chk("rd_held", 32'({mem_rd, mem_wr}), 32'b10);
         tick();
      end
      chk("rd_held_last", 32'(mem_rd), 32'd1);
      man_ready = 1'b1;
      tick();
      man_ready = 1'b0;
      chk("rd_dropped", 32'(mem_rd), 32'd0);
      for (int i = 0; i < 3; i++) begin
         chk("rd_wait_noack", 32'(wb_ack), 32'd0);
         tick();
      end
      man_rvalid = 1'b1;
      man_rdata = 32'h12345678;
      tick();
      man_rvalid = 1'b0;
      chk("rd_ack", 32'(wb_ack), 32'd1);
      chk("rd_data", wb_dat_r, 32'h12345678);
      idle_bus();
      tick();
      chk("rd_single_ack", 32'(wb_ack), 32'd0);

      // Out-of-window accesses below, at and far above the window.
      drive(1'b1, 30'h0FF, 32'h1, 4'hF);
      push(1'b1, 1'b0, 32'd0);
      tick();
      chk("miss_lo_err", 32'({wb_err, mem_wr, mem_rd}), 32'b100);
      idle_bus();
      tick();
      chk("miss_lo_single", 32'(wb_err), 32'd0);
      drive(1'b0, 30'h140, 32'h0, 4'hF);
      push(1'b1, 1'b0, 32'd0);
      tick();
      chk("miss_hi_err", 32'({wb_err, mem_wr, mem_rd}), 32'b100);
      idle_bus();
      tick();
      drive(1'b0, 30'h3FFF_FFFF, 32'h0, 4'hF);
      push(1'b1, 1'b0, 32'd0);
      tick();
      chk("miss_top_err", 32'({wb_err, mem_wr, mem_rd}), 32'b100);
      idle_bus();
      tick();

      // Write with no byte enables acks without touching memory.
      drive(1'b1, 30'h110, 32'hFFFF_FFFF, 4'h0);
      push(1'b0, 1'b0, 32'd0);
      tick();
      chk("sel0_ack", 32'({wb_ack, mem_wr}), 32'b10);
      idle_bus();
      tick();

      // Memory never ready: error after 8 request cycles.
      man_ready = 1'b0;
      drive(1'b1, 30'h101, 32'h5, 4'hF);
      push(1'b1, 1'b0, 32'd0);
      tick();
      for (int i = 0; i < 8; i++) begin
         chk("to_held", 32'({mem_wr, wb_err}), 32'b10);
         tick();
      end
      chk("to_err", 32'({wb_err, mem_wr}), 32'b10);
      idle_bus();
      tick();

      // Read aborted in WAIT_RD; its late return must be drained.
      man_ready = 1'b1;
      drive(1'b0, 30'h102, 32'd0, 4'hF);
      tick();
      tick();
      man_ready = 1'b0;
      idle_bus();
      tick();
      drive(1'b0, 30'h103, 32'd0, 4'hF);
      push(1'b0, 1'b1, 32'h55550000);
      tick();
      chk("drain_no_accept", 32'(mem_rd), 32'd0);
      man_rvalid = 1'b1;
      man_rdata = 32'hAAAA0000;
      tick();
      man_rvalid = 1'b0;
      chk("drain_no_ack", 32'({wb_ack, mem_rd}), 32'd0);
      tick();
      chk("rd2_issue", 32'(mem_rd), 32'd1);
      chk("rd2_addr", 32'(mem_addr), 32'd3);
      man_ready = 1'b1;
      tick();
      man_ready = 1'b0;
      tick();
      man_rvalid = 1'b1;
      man_rdata = 32'h55550000;
      tick();
      man_rvalid = 1'b0;
      chk("rd2_data", wb_dat_r, 32'h55550000);
      idle_bus();
      tick();
      chk("directed_sb_empty", 32'(sb_q.size()), 32'd0);

      // Random back-to-back traffic against the memory model.
      auto_mode = 1'b1;
      for (int t = 0; t < 100; t++) begin
         r_we = 1'($urandom_range(0, 1));
         r_kind = int'($urandom_range(0, 9));
         r_dat = $urandom();
         if (r_kind == 0) begin
            if (t % 2 == 0) r_adr = 30'h0FF - 30'($urandom_range(0, 15));
            else r_adr = 30'h140 + 30'($urandom_range(0, 15));
         end else begin
            r_adr = 30'h100 + 30'($urandom_range(0, 63));
         end
         r_sel = (r_kind == 1) ? 4'h0 : 4'($urandom_range(1, 15));
         if (r_kind == 0) begin
            push(1'b1, 1'b0, 32'd0);
         end else if (r_we) begin
            for (int b = 0; b < 4; b++)
               if (r_sel[b]) ref_mem[r_adr[5:0]][8*b +: 8] = r_dat[8*b +: 8];
            push(1'b0, 1'b0, 32'd0);
         end else begin
            push(1'b0, 1'b1, ref_mem[r_adr[5:0]]);
         end
         drive(r_we, r_adr, r_dat, r_sel);
         guard = 0;
         while (sb_q.size() != 0 && guard < 20) begin
            tick();
            guard++;
         end
         if (sb_q.size() != 0) begin
            chk("rand_no_term", 32'(sb_q.size()), 32'd0);
            sb_q.delete();
         end
         if ($urandom_range(0, 3) == 0) begin
            idle_bus();
            tick();
         end
      end
      idle_bus();
      repeat (4) tick();
      for (int i = 0; i < 64; i++) chk("mem_word", mem_model[i], ref_mem[i]);
      auto_mode = 1'b0;

      // Reset asserted mid-ISSUE clears everything at once.
      man_ready = 1'b0;
      drive(1'b1, 30'h104, 32'hCAFEF00D, 4'h3);
      tick();
      chk("rst_pre_issue", 32'(mem_wr), 32'd1);
      #3;
      reset_n = 1'b0;
      #1;
      chk_all_zero("rst_async");
      idle_bus();
      #2;
      reset_n = 1'b1;
      tick();
      chk("rst_idle", 32'({wb_ack, wb_err, mem_wr, mem_rd}), 32'd0);
      man_ready = 1'b1;
      drive(1'b1, 30'h104, 32'h0BADF00D, 4'hF);
      push(1'b0, 1'b0, 32'd0);
      tick();
      chk("post_rst_wr", 32'(mem_wr), 32'd1);
      chk("post_rst_addr", 32'(mem_addr), 32'd4);
      chk("post_rst_wdata", mem_wdata, 32'h0BADF00D);
      tick();
      chk("post_rst_ack", 32'(wb_ack), 32'd1);
      idle_bus();
      tick();
      chk("final_sb_empty", 32'(sb_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/apf_wishbone_mem_slave.md
# apf_wishbone_mem_slave

Wishbone classic slave that sits directly downstream of the APF-bridge Wishbone master and turns single-beat Wishbone reads/writes into requests on a simple ready/valid word-memory port (SDRAM controller or BRAM wrapper). It decodes one address window, issues exactly one memory access per Wishbone cycle, and returns `wb_ack`, or `wb_err` for out-of-window or timed-out accesses. A late read return after a master abort is drained so it cannot be attributed to a later transfer.

## Interface
Parameters:
- `ADDR_BASE`, 30'h0, first word address of the window (Wishbone word address).
- `ADDR_WORDS`, 30'h0040_0000, window size in 32-bit words; ≤ 2^24.
- `TIMEOUT_CYCLES`, 255, cycles in ISSUE/WAIT_RD/DRAIN before giving up; 8-bit counter, 1..255.

Ports:
- `clk_sys`  in  1  sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `wb_adr`  in  30  word address.
- `wb_dat_w`  in  32  write data.
- `wb_sel`  in  4  byte enables.
- `wb_cyc`, `wb_stb`, `wb_we`  in  1 each  cycle, strobe, write enable.
- `wb_cti`  in  3 / `wb_bte`  in  2  ignored; every access is a classic single beat.
- `wb_dat_r`  out  32  read data, valid while `wb_ack`.
- `wb_ack`, `wb_err`  out  1 each  one-cycle termination pulses.
- `mem_addr`  out  24  word offset `wb_adr - ADDR_BASE`.
- `mem_wr`, `mem_rd`  out  1 each  request strobes, held until `mem_ready`.
- `mem_wdata`  out  32 / `mem_be`  out  4  registered copies of `wb_dat_w` / `wb_sel`.
- `mem_ready`  in  1  memory accepts the request this cycle.
- `mem_rvalid`  in  1 / `mem_rdata`  in  32  read return.

## Operation
- States: IDLE, ISSUE, WAIT_RD, RESP, ERR, DRAIN. Reset: IDLE, and every output plus `wb_dat_r` is 0.
- Window hit: `wb_adr >= ADDR_BASE` and `wb_adr - ADDR_BASE < ADDR_WORDS`. Compute with 31-bit unsigned arithmetic, so there is no wrap at 2^30.
- IDLE, `wb_cyc & wb_stb`:
  - Miss: go to ERR.
  - Write with `wb_sel == 0`: go to RESP and issue no memory access.
  - Otherwise: latch address, data and sel; assert `mem_wr` or `mem_rd`; go to ISSUE and clear the timeout counter.
- ISSUE:
  - `mem_ready` on a write: drop `mem_wr`, go to RESP.
  - `mem_ready` on a read: drop `mem_rd`, go to WAIT_RD.
  - `wb_cyc` low (abort): drop the request and go to IDLE. No ack, no memory access.
- WAIT_RD:
  - `mem_rvalid`: capture `mem_rdata` into `wb_dat_r`, go to RESP.
  - `wb_cyc` low: go to DRAIN.
- DRAIN: wait for `mem_rvalid`, discard the data, go to IDLE. Do not accept new requests in DRAIN.
- RESP: `wb_ack` = 1 for exactly one cycle, then IDLE.
- ERR: `wb_err` = 1 for exactly one cycle, then IDLE.
- Timeout: in ISSUE/WAIT_RD/DRAIN, a counter increments each cycle. When it reaches `TIMEOUT_CYCLES`:
  - ISSUE or WAIT_RD: drop the request and go to ERR.
  - DRAIN: go to IDLE.
- `mem_rvalid` outside WAIT_RD/DRAIN is ignored.
- `wb_ack` and `wb_err` are never high together.
- `mem_ready` and `mem_rvalid` high in the same WAIT_RD cycle: `mem_rvalid` wins.
- Asserting `reset_n` low mid-access returns to IDLE immediately and clears all outputs. The memory side must be reset with it.

## Timing
- All outputs are registered.
- Write, `mem_ready` already high:
  - cycle 0: request sampled.
  - cycle 1: `mem_wr` = 1.
  - cycle 2: `wb_ack` = 1.
  - cycle 3: IDLE, so a new request is sampled.
  - Each cycle `mem_ready` is low inserts one cycle.
- Read: `mem_rvalid` in cycle k gives `wb_ack` with data in cycle k+1.
- Miss: `wb_err` in cycle 1.
- The master may drop `wb_stb` on the edge that samples `wb_ack`. If `wb_stb` is still high in the cycle after RESP, it is a new request.
- At most one outstanding memory request at any time.

## Test plan
- `ADDR_BASE`=0x100, write adr 0x105, dat 0xDEADBEEF, sel F, `mem_ready` tied 1 -> `mem_wr` in cycle 1 with `mem_addr`=5, `mem_be`=F; `wb_ack` single pulse in cycle 2.
- Read adr 0x100, `mem_ready` delayed 3 cycles, `mem_rvalid` 4 cycles later with 0x12345678 -> `wb_dat_r`=0x12345678 with one `wb_ack`; `mem_rd` high exactly until the `mem_ready` cycle.
- Accesses at adr 0xFF and adr `ADDR_BASE+ADDR_WORDS` -> `wb_err` pulse in cycle 1, no `mem_wr`/`mem_rd`. Write with sel 0 -> `wb_ack`, no `mem_wr`.
- `mem_ready` held 0 with `TIMEOUT_CYCLES`=8 -> request dropped and `wb_err` after 8 cycles. Then a read that aborts in WAIT_RD is followed by a new read. The stale `mem_rvalid` (0xAAAA0000) is drained and the second read returns its own data, 0x55550000.
- Back-to-back writes, 100 random transfers against a memory model with random `mem_ready`/`mem_rvalid` stalls -> model contents match, exactly one ack/err per cycle, no overlapping requests.
- Assert `reset_n` low while in ISSUE -> all outputs 0 asynchronously; the first request after release completes normally.
